freq_div_ctrl: RTL and testbench

Configuration sequencer and round-robin arbiter for the programmable frequency divider. It lets NREQ requesters share one divider and reprogram its ratio. Each grant is serialised into a safe disable → load → enable → settle sequence on the divider's Din/ConfigDiv/Enable pins, and the winning requester receives a one-cycle acknowledge. The block sits between the divider and the software-visible or test-harness requesters; it is the only master of the divider's configuration pins.

---
 rtl/freq_div_ctrl.sv | 158 +++++++++++++++
 tb/tb_freq_div_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_div_ctrl.sv
// Round-robin configuration sequencer that is the sole master of the frequency divider's config pins.
// Optional build macro FDC_ZERO_REJECT_EN: reject a requested ratio of 0 with ack+err instead of programming it.
module freq_div_ctrl #(
    parameter int NREQ   = 4,
    parameter int DW     = 32,
    parameter int SETTLE = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*DW-1:0]   req_div,
    output logic [NREQ-1:0]      ack,
    output logic                 err,
    output logic                 busy,
    output logic [DW-1:0]        cur_div,
    output logic [DW-1:0]        div_Din,
    output logic                 div_ConfigDiv,
    output logic                 div_Enable,
    output logic [2:0]           dbg_state
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_DISABLE = 3'd1,
        ST_LOAD    = 3'd2,
        ST_SETTLE  = 3'd3,
        ST_ACK     = 3'd4
    } state_t;

    // Handshake: a requester raises req with its ratio and holds both until it
    // sees its one-cycle ack; req is only sampled while the sequencer is idle.

    state_t          state, next_state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   rr_ptr;
    logic [DW-1:0]   lat_div;
    logic [DW-1:0]   cur_div_q;
    logic [DW-1:0]   din_q;
    logic [CW-1:0]   cnt;
    logic            running;
    logic            reject;

    logic [DW-1:0]   div_arr [NREQ];
    logic            grant_vld;
    logic [IW-1:0]   grant_idx;
    logic [DW-1:0]   grant_div;
    logic            zero_hit;

    for (genvar g = 0; g < NREQ; g++) begin : g_div
        assign div_arr[g] = req_div[g*DW +: DW];
    end

    // Search starts at rr_ptr so the most recently served requester goes last.
    always_comb begin
        int j;
        j         = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(rr_ptr) + k;
            if (j >= NREQ) j = j - NREQ;
            if (!grant_vld && req[IW'(j)]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(j);
            end
        end
    end

    assign grant_div = div_arr[grant_idx];

`ifdef FDC_ZERO_REJECT_EN
    assign zero_hit = (grant_div == '0);
`else
    assign zero_hit = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (grant_vld) next_state = zero_hit ? ST_ACK : ST_DISABLE;
            ST_DISABLE: next_state = ST_LOAD;
            ST_LOAD:    next_state = ST_SETTLE;
            ST_SETTLE:  if (cnt == '0) next_state = ST_ACK;
            ST_ACK:     next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= ST_IDLE;
            idx       <= '0;
            rr_ptr    <= '0;
            lat_div   <= '0;
            cur_div_q <= DW'(1);
            din_q     <= '0;
            cnt       <= '0;
            running   <= 1'b0;
            reject    <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (grant_vld) begin
                        idx     <= grant_idx;
                        lat_div <= grant_div;
                        reject  <= zero_hit;
                    end
                end
                ST_DISABLE: din_q <= lat_div;
                ST_LOAD:    cnt   <= CW'(SETTLE - 1);
                ST_SETTLE:  if (cnt != '0) cnt <= cnt - CW'(1);
                ST_ACK: begin
                    if (int'(idx) == NREQ - 1) rr_ptr <= '0;
                    else                       rr_ptr <= idx + IW'(1);
                    // A rejected ratio leaves the divider exactly as it was.
                    if (!reject) begin
                        cur_div_q <= lat_div;
                        running   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ack           = '0;
        busy          = (state != ST_IDLE);
        div_ConfigDiv = 1'b0;
        div_Enable    = 1'b0;
        case (state)
            ST_IDLE:    div_Enable = running;
            ST_DISABLE: div_Enable = 1'b0;
            ST_LOAD:    div_ConfigDiv = 1'b1;
            ST_SETTLE:  div_Enable = 1'b1;
            ST_ACK: begin
                ack        = NREQ'(1) << idx;
                div_Enable = reject ? running : 1'b1;
            end
            default: ;
        endcase
    end

`ifdef FDC_ZERO_REJECT_EN
    assign err = (state == ST_ACK) && reject;
`else
    assign err = 1'b0;
`endif

    assign cur_div   = cur_div_q;
    assign div_Din   = din_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Directed testbench for freq_div_ctrl: sequencing, round-robin order, zero ratio, reset abort, early req drop.
module tb_freq_div_ctrl;

    localparam int NREQ = 4;
    localparam int DW   = 32;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*DW-1:0] req_div = '0;
    logic [NREQ-1:0]   ack;
    logic              err;
    logic              busy;
    logic [DW-1:0]     cur_div;
    logic [DW-1:0]     div_Din;
    logic              div_ConfigDiv;
    logic              div_Enable;
    logic [2:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    freq_div_ctrl #(.NREQ(NREQ), .DW(DW), .SETTLE(2)) dut (
        .Clk(Clk), .Reset(Reset), .req(req), .req_div(req_div),
        .ack(ack), .err(err), .busy(busy), .cur_div(cur_div),
        .div_Din(div_Din), .div_ConfigDiv(div_ConfigDiv),
        .div_Enable(div_Enable), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        req   = '0;
        tick();
        tick();
        Reset = 1'b0;
    endtask

    // Drivers
    task automatic set_div(input int i, input logic [DW-1:0] v);
        req_div[i*DW +: DW] = v;
    endtask

    // Config strobe must never overlap a running divider.
    always @(negedge Clk) begin
        if (!Reset) begin
            checks++;
            if (div_ConfigDiv && div_Enable) begin
                errors++;
                $display("FAIL cfg_while_enabled: ConfigDiv=%b Enable=%b required Enable=0", div_ConfigDiv, div_Enable);
            end
        end
    end

    task automatic wait_ack(input int limit, output int idx, output int n);
        idx = -1;
        n   = 0;
        while (n < limit) begin
            tick();
            n++;
            if (ack != '0) break;
        end
        checks++;
        if (ack == '0) begin
            errors++;
            $display("FAIL ack_timeout: no ack within %0d cycles", limit);
        end else begin
            checks++;
            if (!$onehot(ack)) begin
                errors++;
                $display("FAIL ack_onehot: ack=%b required one-hot", ack);
            end
            for (int i = 0; i < NREQ; i++) if (ack[i]) idx = i;
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ack !== '0 || err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: ack=%b err=%b busy=%b required 0/0/0", ack, err, busy);
        end
        checks++;
        if (cur_div !== 32'd1 || div_Din !== 32'd0) begin
            errors++;
            $display("FAIL reset_data: cur_div=%0d Din=%0d required 1/0", cur_div, div_Din);
        end
        checks++;
        if (div_ConfigDiv !== 1'b0 || div_Enable !== 1'b0 || dbg_state !== 3'd0) begin
            errors++;
            $display("FAIL reset_pins: cfg=%b en=%b state=%0d required 0/0/0", div_ConfigDiv, div_Enable, dbg_state);
        end
    endtask

    task automatic test_single_program();
        logic [5:0] exp_en   = 6'b111100;
        logic [5:0] exp_cfg  = 6'b000010;
        logic [5:0] exp_busy = 6'b011111;
        logic [5:0] exp_ack  = 6'b010000;
        do_reset();
        set_div(0, 32'd5);
        req = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (k == 4) req = '0;
            checks++;
            if (div_Enable !== exp_en[k] || div_ConfigDiv !== exp_cfg[k] || busy !== exp_busy[k]) begin
                errors++;
                $display("FAIL single_pins[%0d]: en=%b cfg=%b busy=%b required %b/%b/%b", k + 1,
                         div_Enable, div_ConfigDiv, busy, exp_en[k], exp_cfg[k], exp_busy[k]);
            end
            checks++;
            if (ack !== {3'b000, exp_ack[k]}) begin
                errors++;
                $display("FAIL single_ack[%0d]: ack=%b required %b", k + 1, ack, {3'b000, exp_ack[k]});
            end
            if (k == 1) begin
                checks++;
                if (div_Din !== 32'd5) begin
                    errors++;
                    $display("FAIL single_din: Din=%0d required 5", div_Din);
                end
            end
        end
        checks++;
        if (cur_div !== 32'd5) begin
            errors++;
            $display("FAIL single_cur_div: cur_div=%0d required 5", cur_div);
        end
    endtask

    task automatic test_round_robin();
        int idx, n;
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            set_div(i, 32'(2 + i));
            exp_q.push_back(2'(i));
        end
        req = 4'b1111;
        for (int t = 0; t < NREQ; t++) begin
            logic [1:0] e;
            wait_ack(20, idx, n);
            e = exp_q.pop_front();
            if (idx >= 0) req[idx] = 1'b0;
            checks++;
            if (idx != int'(e)) begin
                errors++;
                $display("FAIL rr_order[%0d]: granted=%0d required %0d", t, idx, e);
            end
            checks++;
            if (n != ((t == 0) ? 5 : 6)) begin
                errors++;
                $display("FAIL rr_spacing[%0d]: cycles=%0d required %0d", t, n, (t == 0) ? 5 : 6);
            end
        end
        tick();
        checks++;
        if (cur_div !== 32'd5) begin
            errors++;
            $display("FAIL rr_cur_div: cur_div=%0d required 5", cur_div);
        end
    endtask

    task automatic test_back_to_back_wrap();
        int idx, n;
        do_reset();
        set_div(0, 32'd11);
        set_div(2, 32'd13);
        req = 4'b0100;
        wait_ack(20, idx, n);
        checks++;
        if (idx != 2) begin
            errors++;
            $display("FAIL wrap_first: granted=%0d required 2", idx);
        end
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd2);
        req = 4'b0101;
        for (int t = 0; t < 2; t++) begin
            logic [1:0] e;
            wait_ack(20, idx, n);
            e = exp_q.pop_front();
            if (idx >= 0) req[idx] = 1'b0;
            checks++;
            if (idx != int'(e) || n != 6) begin
                errors++;
                $display("FAIL wrap_order[%0d]: granted=%0d after %0d cycles required %0d after 6", t, idx, n, e);
            end
        end
        tick();
        checks++;
        if (cur_div !== 32'd13) begin
            errors++;
            $display("FAIL wrap_cur_div: cur_div=%0d required 13", cur_div);
        end
    endtask

    task automatic test_zero_ratio();
        int idx, n;
        do_reset();
        set_div(1, 32'd0);
        req = 4'b0010;
        wait_ack(20, idx, n);
        req = '0;
        checks++;
        if (idx != 1) begin
            errors++;
            $display("FAIL zero_idx: granted=%0d required 1", idx);
        end
`ifdef FDC_ZERO_REJECT_EN
        checks++;
        if (n != 1 || err !== 1'b1 || div_Enable !== 1'b0) begin
            errors++;
            $display("FAIL zero_reject: cycles=%0d err=%b en=%b required 1/1/0", n, err, div_Enable);
        end
        tick();
        checks++;
        if (cur_div !== 32'd1 || div_Din !== 32'd0 || err !== 1'b0) begin
            errors++;
            $display("FAIL zero_unchanged: cur_div=%0d Din=%0d err=%b required 1/0/0", cur_div, div_Din, err);
        end
`else
        checks++;
        if (n != 5 || err !== 1'b0) begin
            errors++;
            $display("FAIL zero_program: cycles=%0d err=%b required 5/0", n, err);
        end
        tick();
        checks++;
        if (cur_div !== 32'd0 || div_Enable !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL zero_cur_div: cur_div=%0d en=%b err=%b required 0/1/0", cur_div, div_Enable, err);
        end
`endif
    endtask

    task automatic test_reset_mid_sequence();
        do_reset();
        set_div(0, 32'd7);
        req = 4'b0001;
        tick();
        tick();
        tick();
        checks++;
        if (div_Enable !== 1'b1 || dbg_state !== 3'd3) begin
            errors++;
            $display("FAIL abort_pre: en=%b state=%0d required 1/3", div_Enable, dbg_state);
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        req   = '0;
        checks++;
        if (ack !== '0 || busy !== 1'b0 || div_Enable !== 1'b0 || cur_div !== 32'd1 || div_Din !== 32'd0) begin
            errors++;
            $display("FAIL abort_post: ack=%b busy=%b en=%b cur_div=%0d Din=%0d required 0/0/0/1/0",
                     ack, busy, div_Enable, cur_div, div_Din);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (ack !== '0 || div_Enable !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_idle[%0d]: ack=%b en=%b busy=%b required 0/0/0", k, ack, div_Enable, busy);
            end
        end
    endtask

    task automatic test_req_drop();
        do_reset();
        set_div(3, 32'd9);
        req = 4'b1000;
        tick();
        tick();
        checks++;
        if (div_ConfigDiv !== 1'b1 || div_Din !== 32'd9) begin
            errors++;
            $display("FAIL drop_load: cfg=%b Din=%0d required 1/9", div_ConfigDiv, div_Din);
        end
        req = '0;
        tick();
        tick();
        checks++;
        if (ack !== '0) begin
            errors++;
            $display("FAIL drop_early_ack: ack=%b required 0000", ack);
        end
        tick();
        checks++;
        if (ack !== 4'b1000) begin
            errors++;
            $display("FAIL drop_ack: ack=%b required 1000", ack);
        end
        tick();
        checks++;
        if (cur_div !== 32'd9 || busy !== 1'b0 || ack !== '0) begin
            errors++;
            $display("FAIL drop_done: cur_div=%0d busy=%b ack=%b required 9/0/0000", cur_div, busy, ack);
        end
    endtask

    initial begin
        test_reset();
        test_single_program();
        test_round_robin();
        test_back_to_back_wrap();
        test_zero_ratio();
        test_reset_mid_sequence();
        test_req_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
